// File: rtl/clk_mon_pkg.sv
// Shared types and helpers for the clock frequency monitor.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package clk_mon_pkg;

    // Lock state machine encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } mon_state_t;

    // Lower acceptance bound; clamps at zero when the tolerance exceeds the target
    function automatic int tol_lo(input int exp_cnt, input int tol);
        return (exp_cnt > tol) ? (exp_cnt - tol) : 0;
    endfunction

    // Upper acceptance bound, clamped to the largest value a cnt_w-bit counter holds
    function automatic int tol_hi(input int exp_cnt, input int tol, input int cnt_w);
        int max_v;
        max_v = (1 << cnt_w) - 1;
        return ((exp_cnt + tol) > max_v) ? max_v : (exp_cnt + tol);
    endfunction

endpackage

// File: rtl/clk_edge_sync.sv
// Brings the clock under test into the clk_100m domain and flags its rising edges.
// Latency: a clk_in rising edge shows up as a one-cycle rise pulse ~3 clk_100m cycles later.
// Backpressure: none; free-running sampler.
module clk_edge_sync (
    input  logic clk_100m,
    input  logic rst,
    input  logic i_clk_in,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Two metastability flops followed by one delay flop for edge detection
    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_clk_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/clk_freq_monitor.sv
// Counts clk_in rising edges per gate window, judges them against a tolerance band and tracks lock.
// Latency: freq_vld pulses 1 cycle after the last gate cycle; locked/lost_pulse/err_cnt 1 cycle after freq_vld.
// Backpressure: none; en=0 drops the partial window. Optional period measurement: CLK_MON_PERIOD_EN.
module clk_freq_monitor
    import clk_mon_pkg::*;
#(
    parameter int GATE_CYCLES = 1000,
    parameter int EXP_CNT     = 250,
    parameter int TOL         = 2,
    parameter int LOCK_WINS   = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk_100m,
    input  logic             rst,
    input  logic             en,
    input  logic             clk_in,
    output logic [CNT_W-1:0] freq_cnt,
    output logic             freq_vld,
    output logic [7:0]       period_cyc,
    output logic             locked,
    output logic             lost_pulse,
    output logic [7:0]       err_cnt
);

    localparam int               GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] WIN_LO    = CNT_W'(tol_lo(EXP_CNT, TOL));
    localparam logic [CNT_W-1:0] WIN_HI    = CNT_W'(tol_hi(EXP_CNT, TOL, CNT_W));
    localparam logic [7:0]       LOCK_N    = 8'(LOCK_WINS);

    logic [GW-1:0]    r_gate_cnt;
    logic [CNT_W-1:0] r_edge_cnt;
    logic [CNT_W-1:0] r_freq_cnt;
    logic             r_freq_vld;
    mon_state_t       r_state;
    logic [7:0]       r_good_cnt;
    logic             r_lost;
    logic [7:0]       r_err_cnt;

    logic             w_rise;
    logic             w_eow;
    logic [CNT_W:0]   w_sum;
    logic             w_good;

    clk_edge_sync u_sync (
        .clk_100m (clk_100m),
        .rst      (rst),
        .i_clk_in (clk_in),
        .o_rise   (w_rise)
    );

    // en is folded in so a window closing as en falls never reports
    assign w_eow  = en && (r_gate_cnt == GATE_LAST);
    // An edge landing in the closing cycle still belongs to this window
    assign w_sum  = {1'b0, r_edge_cnt} + {{CNT_W{1'b0}}, w_rise};
    assign w_good = (r_freq_cnt >= WIN_LO) && (r_freq_cnt <= WIN_HI);

    // Gate window counter: 0..GATE_CYCLES-1, restarts from 0 whenever en drops
    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            r_gate_cnt <= '0;
        end else if (!en || (r_gate_cnt == GATE_LAST)) begin
            r_gate_cnt <= '0;
        end else begin
            r_gate_cnt <= r_gate_cnt + 1'b1;
        end
    end

    // Edge counter, saturating, cleared at window close or when disabled
    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            r_edge_cnt <= '0;
        end else if (!en || w_eow) begin
            r_edge_cnt <= '0;
        end else if (w_rise && (r_edge_cnt != CNT_MAX)) begin
            r_edge_cnt <= r_edge_cnt + 1'b1;
        end
    end

    // Latch the completed window count and flag it for one cycle
    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            r_freq_cnt <= '0;
            r_freq_vld <= 1'b0;
        end else begin
            r_freq_vld <= w_eow;
            if (w_eow) begin
                r_freq_cnt <= w_sum[CNT_W] ? CNT_MAX : w_sum[CNT_W-1:0];
            end
        end
    end

    // Lock state machine: judges each window in its freq_vld cycle
    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_good_cnt <= '0;
            r_lost     <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_lost <= 1'b0;
            if (!en) begin
                r_state    <= ST_IDLE;
                r_good_cnt <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state    <= ST_ACQ;
                        r_good_cnt <= '0;
                    end
                    ST_ACQ: begin
                        if (r_freq_vld) begin
                            if (w_good) begin
                                r_good_cnt <= r_good_cnt + 8'd1;
                                if ((r_good_cnt + 8'd1) >= LOCK_N) begin
                                    r_state <= ST_LOCKED;
                                end
                            end else begin
                                r_good_cnt <= '0;
                                if (r_err_cnt != 8'hFF) begin
                                    r_err_cnt <= r_err_cnt + 8'd1;
                                end
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (r_freq_vld && !w_good) begin
                            r_state    <= ST_ACQ;
                            r_lost     <= 1'b1;
                            r_good_cnt <= '0;
                            if (r_err_cnt != 8'hFF) begin
                                r_err_cnt <= r_err_cnt + 8'd1;
                            end
                        end
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        r_good_cnt <= '0;
                    end
                endcase
            end
        end
    end

`ifdef CLK_MON_PERIOD_EN
    logic [7:0] r_per_cnt;
    logic [7:0] r_period;

    // Cycles between successive rises; the first sample after (re)enable is partial
    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            r_per_cnt <= '0;
            r_period  <= '0;
        end else if (!en) begin
            r_per_cnt <= '0;
        end else if (w_rise) begin
            r_period  <= (r_per_cnt == 8'hFF) ? 8'hFF : (r_per_cnt + 8'd1);
            r_per_cnt <= '0;
        end else if (r_per_cnt != 8'hFF) begin
            r_per_cnt <= r_per_cnt + 8'd1;
        end
    end

    assign period_cyc = r_period;
`else
    assign period_cyc = 8'd0;
`endif

    assign freq_cnt   = r_freq_cnt;
    assign freq_vld   = r_freq_vld;
    assign locked     = (r_state == ST_LOCKED);
    assign lost_pulse = r_lost;
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Scoreboard bench for clk_freq_monitor: directed phases push expected window results,
// a monitor pops them on each freq_vld and checks the judgement one cycle later.
// Two extra instances probe the tolerance band edges (EXP_CNT 248 / 247).
module tb_clk_freq_monitor;

    logic        clk_100m;
    logic        rst;
    logic        en;
    logic        clk_in;

    logic [15:0] freq_cnt;
    logic        freq_vld;
    logic [7:0]  period_cyc;
    logic        locked;
    logic        lost_pulse;
    logic [7:0]  err_cnt;

    logic [15:0] a_freq_cnt, b_freq_cnt;
    logic        a_freq_vld, b_freq_vld;
    logic [7:0]  a_period, b_period;
    logic        a_locked, b_locked;
    logic        a_lost, b_lost;
    logic [7:0]  a_err, b_err;

    int checks = 0;
    int errors = 0;
    int gen_mode = 1;

    typedef struct {
        int lo;
        int hi;
        int lk;
        int lost;
        int err;
        int per;
    } exp_t;

    exp_t exp_q[$];

    clk_freq_monitor dut (
        .clk_100m(clk_100m), .rst(rst), .en(en), .clk_in(clk_in),
        .freq_cnt(freq_cnt), .freq_vld(freq_vld), .period_cyc(period_cyc),
        .locked(locked), .lost_pulse(lost_pulse), .err_cnt(err_cnt)
    );

    clk_freq_monitor #(.EXP_CNT(248)) dut_248 (
        .clk_100m(clk_100m), .rst(rst), .en(en), .clk_in(clk_in),
        .freq_cnt(a_freq_cnt), .freq_vld(a_freq_vld), .period_cyc(a_period),
        .locked(a_locked), .lost_pulse(a_lost), .err_cnt(a_err)
    );

    clk_freq_monitor #(.EXP_CNT(247)) dut_247 (
        .clk_100m(clk_100m), .rst(rst), .en(en), .clk_in(clk_in),
        .freq_cnt(b_freq_cnt), .freq_vld(b_freq_vld), .period_cyc(b_period),
        .locked(b_locked), .lost_pulse(b_lost), .err_cnt(b_err)
    );

    initial begin
        clk_100m = 1'b0;
        forever #5 clk_100m = ~clk_100m;
    end

    // Divider for clk_in, updated 3 time units after each clk_100m edge
    initial begin
        int cnt;
        int half;
        cnt    = 0;
        clk_in = 1'b0;
        forever begin
            @(posedge clk_100m);
            #3;
            case (gen_mode)
                1:       half = 2;
                2:       half = 5;
                default: half = 0;
            endcase
            if (half == 0) begin
                clk_in = 1'b0;
                cnt    = 0;
            end else if (cnt == half - 1) begin
                clk_in = ~clk_in;
                cnt    = 0;
            end else begin
                cnt++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    function automatic int pexp(input int v);
        int r;
        r = v;
`ifndef CLK_MON_PERIOD_EN
        r = 0;
`endif
        return r;
    endfunction

    task automatic push(input int lo, input int hi, input int lk, input int lost,
                        input int err, input int per);
        exp_t e;
        e.lo = lo; e.hi = hi; e.lk = lk; e.lost = lost; e.err = err; e.per = pexp(per);
        exp_q.push_back(e);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk_100m);
    endtask

    // Monitor: compare every freq_vld against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_100m);
            if (freq_vld) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_freq_vld", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk_rng("freq_cnt", int'(freq_cnt), e.lo, e.hi);
                    chk("period_cyc", int'(period_cyc), e.per);
                    @(negedge clk_100m);
                    chk("locked", int'(locked), e.lk);
                    chk("lost_pulse", int'(lost_pulse), e.lost);
                    chk("err_cnt", int'(err_cnt), e.err);
                    @(negedge clk_100m);
                    chk("lost_pulse_width", int'(lost_pulse), 0);
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        gen_mode = 1;
        wait_neg(3);
        chk("rst_freq_cnt", int'(freq_cnt), 0);
        chk("rst_freq_vld", int'(freq_vld), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_period", int'(period_cyc), 0);
        chk("rst_lost", int'(lost_pulse), 0);
        rst = 1'b0;
        wait_neg(20);

        // 25 MHz lock, then clk_in dies just before window 4 closes
        en = 1'b1;
        push(250, 250, 0, 0, 0, 4);
        push(250, 250, 0, 0, 0, 4);
        push(250, 250, 0, 0, 0, 4);
        push(249, 250, 1, 0, 0, 4);
        push(0,   0,   0, 1, 1, 4);
        wait_neg(3995);
        gen_mode = 0;
        wait_neg(8);
        chk("tol248_locked", int'(a_locked), 1);
        chk("tol247_locked", int'(b_locked), 0);
        wait_neg(1008);
        en = 1'b0;
        wait_neg(5);
        chk("dis_locked", int'(locked), 0);
        chk("dis_err_held", int'(err_cnt), 1);

        // en dropped mid-window, then a fresh window after re-enable
        gen_mode = 1;
        wait_neg(20);
        en = 1'b1;
        push(250, 250, 0, 0, 1, 4);
        wait_neg(1500);
        en = 1'b0;
        wait_neg(50);
        chk("hold_freq_cnt", int'(freq_cnt), 250);
        chk("hold_locked", int'(locked), 0);
        en = 1'b1;
        push(250, 250, 0, 0, 1, 4);
        push(250, 250, 0, 0, 1, 4);
        push(250, 250, 0, 0, 1, 4);
        push(250, 250, 1, 0, 1, 4);
        wait_neg(999);
        chk("reen_no_early_vld", int'(freq_vld), 0);
        wait_neg(1);
        chk("reen_vld_at_1000", int'(freq_vld), 1);
        wait_neg(3003);
        chk("tol248_relock", int'(a_locked), 1);
        chk("tol247_never", int'(b_locked), 0);
        wait_neg(498);

        // Asynchronous reset while locked, mid-window
        chk("pre_rst_locked", int'(locked), 1);
        rst = 1'b1;
        #1;
        chk("arst_freq_cnt", int'(freq_cnt), 0);
        chk("arst_locked", int'(locked), 0);
        chk("arst_err_cnt", int'(err_cnt), 0);
        chk("arst_period", int'(period_cyc), 0);
        wait_neg(2);
        rst = 1'b0;
        push(249, 251, 0, 0, 0, 4);
        push(250, 250, 0, 0, 0, 4);
        push(250, 250, 0, 0, 0, 4);
        push(250, 250, 1, 0, 0, 4);
        wait_neg(4005);
        en = 1'b0;

        // 10 MHz: every window bad, never locks
        gen_mode = 2;
        wait_neg(20);
        en = 1'b1;
        push(100, 100, 0, 0, 1, 10);
        push(100, 100, 0, 0, 2, 10);
        push(100, 100, 0, 0, 3, 10);
        wait_neg(3010);
        en = 1'b0;
        wait_neg(10);
        chk("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_freq_monitor.md
Name: clk_freq_monitor

Overview:
- Measures a slow clock (e.g. the divided 10 MHz or 25 MHz clock) in the clk_100m domain. The input is sampled as data, not used as a clock.
- Counts rising edges in a fixed gate window and checks the count against an expected value plus tolerance.
- Runs a lock state machine and reports frequency, period, lock status and error counts to the control/status registers.

Parameters:
- GATE_CYCLES, 1000, gate window length in clk_100m cycles (10 us).
- EXP_CNT, 250, expected rising edges per window (25 MHz).
- TOL, 2, allowed absolute deviation from EXP_CNT.
- LOCK_WINS, 4, consecutive good windows needed to lock.
- CNT_W, 16, width of the edge and frequency counters.

Ports:
- clk_100m  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  monitor enable, synchronous to clk_100m.
- clk_in  in  1  clock under test, asynchronous, at most 25 MHz.
- freq_cnt  out  CNT_W  edge count of the last completed window.
- freq_vld  out  1  one-cycle pulse when freq_cnt updates.
- period_cyc  out  8  clk_100m cycles between the last two rising edges.
- locked  out  1  high while the state machine is in LOCKED.
- lost_pulse  out  1  one-cycle pulse on the LOCKED->ACQ transition.
- err_cnt  out  8  number of bad windows, saturating at 255.

Behaviour:
- Reset: one clock, clk_100m; reset is asynchronous and active-high on port rst. All outputs and internal registers clear to 0 immediately when rst is asserted; state goes to IDLE.
- Input path: clk_in passes through a 2-flop synchronizer plus one delay flop. rise = s2 & ~s3, so a clk_in edge appears as rise 3 clk_100m cycles later. Minimum high/low time on clk_in is 2 clk_100m cycles.
- Gate counter (gate_cnt): counts 0..GATE_CYCLES-1 while en=1, then wraps to 0.
- Edge counter (edge_cnt): increments on rise and saturates at all-ones.
- End of window (gate_cnt == GATE_CYCLES-1):
  - freq_cnt <= edge_cnt + rise, saturating, so an edge in the last cycle is counted.
  - edge_cnt <= 0.
  - freq_vld pulses on the next cycle (1-cycle latency).
- Window judgement:
  - good = (freq_cnt >= EXP_CNT-TOL, with the lower bound clamped at 0) && (freq_cnt <= EXP_CNT+TOL).
  - Evaluated in the cycle freq_vld is high.
- FSM states: IDLE, ACQ, LOCKED.
  - IDLE: en=1 -> ACQ; good_cnt <= 0.
  - ACQ, good window: good_cnt++. When good_cnt reaches LOCK_WINS -> LOCKED; locked rises on the following cycle.
  - ACQ, bad window: good_cnt <= 0 and err_cnt++.
  - LOCKED, bad window: -> ACQ, lost_pulse=1 for one cycle, err_cnt++, good_cnt <= 0.
  - Any state, en=0: -> IDLE synchronously.
- en=0 effects:
  - Immediate: gate_cnt, edge_cnt, good_cnt and locked are cleared.
  - Held: freq_cnt, period_cyc, err_cnt.
  - The partial window is discarded and no freq_vld is issued.
  - Re-enable starts a fresh full window at gate_cnt=0.
- Simultaneous events:
  - rise in the end-of-window cycle: counted into the closing window.
  - en falling in the end-of-window cycle: en has priority, no freq_vld.
- Dead clock: freq_cnt=0 is a normal bad window.

Optional Feature:
- CLK_MON_PERIOD_EN defined:
  - per_cnt increments every cycle, saturating at 255.
  - On rise: period_cyc <= per_cnt + 1, per_cnt <= 0.
  - Expected values: 25 MHz -> 4, 10 MHz -> 10.
  - The first value after reset or re-enable is invalid; period_cyc is valid from the second rise.
- CLK_MON_PERIOD_EN undefined: period_cyc is tied to 0 and no period logic is generated.

Decomposition:
- Package clk_mon_pkg: FSM state enum (IDLE, ACQ, LOCKED); helper constants for the tolerance bounds (lo/hi computed with clamping).
- Sub-module clk_edge_sync: 2-flop synchronizer + delay flop, outputs the rise pulse; async reset on rst.

Test Plan:
- 25 MHz clk_in from the divider, defaults, en=1 -> freq_cnt=250 (+/-1 for phase) every 1000 cycles; locked high after 4th freq_vld; period_cyc=4; err_cnt=0.
- 10 MHz clk_in -> freq_cnt=100 each window; locked never rises; err_cnt increments by 1 per window; period_cyc=10.
- Locked on 25 MHz, then clk_in held low -> next window freq_cnt=0; lost_pulse single cycle; locked=0; err_cnt=1; state ACQ.
- Tolerance edges, 25 MHz input: EXP_CNT=248, TOL=2 -> locks; EXP_CNT=247, TOL=2 -> freq_cnt=250 judged bad, never locks.
- en dropped at gate_cnt=500 then raised -> no freq_vld for the partial window; next freq_vld 1000 cycles after re-enable; freq_cnt held meanwhile.
- rst pulsed asynchronously mid-window while locked -> all outputs 0 without waiting for a clock edge; after release, normal relock after 4 windows.
